// File: rtl/systolic_tile_sequencer.sv
// rtl/systolic_tile_sequencer.sv - output-stationary systolic tile sequencer with skewed feeds and per-PE completion map
module systolic_tile_sequencer #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_valid,
    output logic                                   start_ready,
    output logic                                   busy,
    output logic [$clog2(DEPTH+2*SIZE-1)-1:0]      cnt,
    output logic [SIZE-1:0]                        row_feed_en,
    output logic [SIZE-1:0]                        col_feed_en,
    output logic [SIZE*SIZE-1:0]                   pe_first,
    output logic [SIZE*SIZE-1:0]                   pe_done,
    output logic                                   done_valid,
    input  logic                                   done_ready
);

    localparam int CW   = $clog2(DEPTH + 2 * SIZE - 1);
    localparam int LAST = DEPTH + 2 * SIZE - 2;
    localparam logic [CW-1:0] LAST_C = CW'(LAST);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SIZE*SIZE-1:0]   pe_done_q, pe_done_d;
    logic                   start_ready_q, start_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_valid_q, done_valid_d;

    // Counter widened to 32 bits so diagonal bounds like r+DEPTH never wrap.
    logic [31:0]            cnt_ext;
    logic [SIZE-1:0]        feed_en;

    assign cnt_ext = 32'(cnt_q);

    // Skewed operand feed window: edge lane r is live for DEPTH cycles starting at cnt=r.
    always_comb begin
        feed_en = '0;
        if (state_q == S_RUN) begin
            for (int r = 0; r < SIZE; r++) begin
                if (cnt_ext >= $unsigned(r) && cnt_ext < $unsigned(r + DEPTH)) begin
                    feed_en[r] = 1'b1;
                end
            end
        end
    end

    // PE(i,j) sees its k=0 operand when the wavefront reaches diagonal i+j.
    always_comb begin
        pe_first = '0;
        if (state_q == S_RUN) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    if (cnt_ext == $unsigned(i + j)) begin
                        pe_first[i*SIZE+j] = 1'b1;
                    end
                end
            end
        end
    end

    // Next-state, counter and sticky completion map; status outputs follow the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pe_done_d = pe_done_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_valid) begin
                    state_d   = S_RUN;
                    pe_done_d = '0;
                end
            end
            S_RUN: begin
                for (int i = 0; i < SIZE; i++) begin
                    for (int j = 0; j < SIZE; j++) begin
                        if (cnt_ext == $unsigned(i + j + DEPTH - 1)) begin
                            pe_done_d[i*SIZE+j] = 1'b1;
                        end
                    end
                end
                if (cnt_q == LAST_C) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        start_ready_d = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        done_valid_d  = (state_d == S_DONE);
    end

    // State, counter, completion map and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pe_done_q     <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pe_done_q     <= pe_done_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            done_valid_q  <= done_valid_d;
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign done_valid  = done_valid_q;
    assign cnt         = cnt_q;
    assign pe_done     = pe_done_q;
    assign row_feed_en = feed_en;
    assign col_feed_en = feed_en;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// tb/tb_systolic_tile_sequencer.sv - scoreboard bench for systolic_tile_sequencer
module tb_systolic_tile_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    // SIZE=8, DEPTH=4
    logic        a_sv, a_sr, a_busy, a_dv, a_dr;
    logic [4:0]  a_cnt;
    logic [7:0]  a_row, a_col;
    logic [63:0] a_first, a_done;
    // SIZE=2, DEPTH=1
    logic        b_sv, b_sr, b_busy, b_dv, b_dr;
    logic [1:0]  b_cnt;
    logic [1:0]  b_row, b_col;
    logic [3:0]  b_first, b_done;
    // SIZE=4, DEPTH=16
    logic        c_sv, c_sr, c_busy, c_dv, c_dr;
    logic [4:0]  c_cnt;
    logic [3:0]  c_row, c_col;
    logic [15:0] c_first, c_done;

    systolic_tile_sequencer #(.SIZE(8), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .start_valid(a_sv), .start_ready(a_sr), .busy(a_busy),
        .cnt(a_cnt), .row_feed_en(a_row), .col_feed_en(a_col), .pe_first(a_first),
        .pe_done(a_done), .done_valid(a_dv), .done_ready(a_dr)
    );
    systolic_tile_sequencer #(.SIZE(2), .DEPTH(1)) u_b (
        .clk(clk), .rst(rst), .start_valid(b_sv), .start_ready(b_sr), .busy(b_busy),
        .cnt(b_cnt), .row_feed_en(b_row), .col_feed_en(b_col), .pe_first(b_first),
        .pe_done(b_done), .done_valid(b_dv), .done_ready(b_dr)
    );
    systolic_tile_sequencer #(.SIZE(4), .DEPTH(16)) u_c (
        .clk(clk), .rst(rst), .start_valid(c_sv), .start_ready(c_sr), .busy(c_busy),
        .cnt(c_cnt), .row_feed_en(c_row), .col_feed_en(c_col), .pe_first(c_first),
        .pe_done(c_done), .done_valid(c_dv), .done_ready(c_dr)
    );

    typedef struct {
        int          c;
        logic [7:0]  feed;
        logic [63:0] first;
        logic [63:0] done;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  row_seen  [0:31];
    logic [63:0] done_seen [0:31];

    function automatic logic [63:0] m_feed(int s, int d, int c);
        logic [63:0] v = '0;
        for (int r = 0; r < s; r++) if (c >= r && c < r + d) v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] m_first(int s, int c);
        logic [63:0] v = '0;
        for (int i = 0; i < s; i++)
            for (int j = 0; j < s; j++)
                if (c == i + j) v[i*s+j] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] m_done(int s, int d, int c);
        logic [63:0] v = '0;
        for (int i = 0; i < s; i++)
            for (int j = 0; j < s; j++)
                if (c >= i + j + d) v[i*s+j] = 1'b1;
        return v;
    endfunction

    task automatic push_tile();
        exp_t        e;
        logic [63:0] f;
        for (int c = 0; c <= 18; c++) begin
            f       = m_feed(8, 4, c);
            e.c     = c;
            e.feed  = f[7:0];
            e.first = m_first(8, c);
            e.done  = m_done(8, 4, c);
            sb.push_back(e);
        end
    endtask

    // Called at a negedge; the handshake edge follows.
    task automatic start_a();
        a_sv = 1'b1;
        vectors++;
        if (a_sr !== 1'b1) begin
            miscompares++;
            $display("FAIL start_ready_before_start: got %b want 1", a_sr);
        end
        @(posedge clk);
        push_tile();
    endtask

    task automatic run_a(input bit toggle, input int abort_at, output int n);
        exp_t e;
        n = -1;
        for (int idx = 0; idx < 200; idx++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                vectors++;
                if (a_dv !== 1'b1 || a_busy !== 1'b1 || a_sr !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_state: dv=%b busy=%b sr=%b want 1 1 0", a_dv, a_busy, a_sr);
                end
                vectors++;
                if (a_done !== {64{1'b1}}) begin
                    miscompares++;
                    $display("FAIL done_map_full: got %h want all ones", a_done);
                end
                vectors++;
                if (a_cnt !== 5'd18 || a_row !== 8'h00 || a_col !== 8'h00 || a_first !== 64'h0) begin
                    miscompares++;
                    $display("FAIL done_outputs: cnt=%0d row=%h col=%h first=%h want 18 0 0 0", a_cnt, a_row, a_col, a_first);
                end
                n    = idx;
                a_sv = 1'b0;
                return;
            end
            e = sb.pop_front();
            vectors++;
            if (a_cnt !== 5'(e.c)) begin
                miscompares++;
                $display("FAIL cnt: got %0d want %0d", a_cnt, e.c);
            end
            vectors++;
            if (a_row !== e.feed || a_col !== e.feed) begin
                miscompares++;
                $display("FAIL feed cnt=%0d: row=%h col=%h want %h", e.c, a_row, a_col, e.feed);
            end
            vectors++;
            if (a_first !== e.first) begin
                miscompares++;
                $display("FAIL pe_first cnt=%0d: got %h want %h", e.c, a_first, e.first);
            end
            vectors++;
            if (a_done !== e.done) begin
                miscompares++;
                $display("FAIL pe_done cnt=%0d: got %h want %h", e.c, a_done, e.done);
            end
            vectors++;
            if (a_busy !== 1'b1 || a_dv !== 1'b0 || a_sr !== 1'b0) begin
                miscompares++;
                $display("FAIL run_status cnt=%0d: busy=%b dv=%b sr=%b want 1 0 0", e.c, a_busy, a_dv, a_sr);
            end
            row_seen[e.c]  = a_row;
            done_seen[e.c] = a_done;
            if (e.c == abort_at) begin
                rst  = 1'b1;
                a_sv = 1'b0;
                n    = idx;
                return;
            end
            a_sv = toggle && ($urandom_range(1, 0) == 1);
        end
        vectors++;
        miscompares++;
        $display("FAIL run_timeout: no done_valid within 200 cycles");
    endtask

    // Called at a negedge while in DONE; returns at the negedge after the handshake.
    task automatic release_a();
        a_sv = 1'b0;
        a_dr = 1'b1;
        @(negedge clk);
        a_dr = 1'b0;
        vectors++;
        if (a_sr !== 1'b1 || a_busy !== 1'b0 || a_dv !== 1'b0 || a_cnt !== 5'd0) begin
            miscompares++;
            $display("FAIL release_idle: sr=%b busy=%b dv=%b cnt=%0d want 1 0 0 0", a_sr, a_busy, a_dv, a_cnt);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        a_sv = 1'b0; a_dr = 1'b0;
        b_sv = 1'b0; b_dr = 1'b0;
        c_sv = 1'b0; c_dr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (a_sr !== 1'b1 || a_busy !== 1'b0 || a_dv !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: sr=%b busy=%b dv=%b want 1 0 0", a_sr, a_busy, a_dv);
        end
        vectors++;
        if (a_cnt !== 5'd0 || a_row !== 8'h00 || a_col !== 8'h00 || a_first !== 64'h0 || a_done !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: cnt=%0d row=%h col=%h first=%h done=%h want all 0", a_cnt, a_row, a_col, a_first, a_done);
        end
        vectors++;
        if (b_sr !== 1'b1 || c_sr !== 1'b1 || b_done !== 4'h0 || c_done !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_corner: b_sr=%b c_sr=%b b_done=%h c_done=%h want 1 1 0 0", b_sr, c_sr, b_done, c_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_tile();
        int n;
        @(negedge clk);
        start_a();
        run_a(1'b0, -1, n);
        vectors++;
        if (n !== 19) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d want 19", n);
        end
        vectors++;
        if (row_seen[0] !== 8'h01 || row_seen[3] !== 8'h0F || row_seen[7] !== 8'hF0 ||
            row_seen[10] !== 8'h80 || row_seen[11] !== 8'h00) begin
            miscompares++;
            $display("FAIL basic_row_points: %h %h %h %h %h want 01 0f f0 80 00",
                     row_seen[0], row_seen[3], row_seen[7], row_seen[10], row_seen[11]);
        end
    endtask

    // Uses the map captured by the preceding basic tile.
    task automatic test_completion_map();
        vectors++;
        if (done_seen[3][0] !== 1'b0 || done_seen[4][0] !== 1'b1) begin
            miscompares++;
            $display("FAIL map_bit0: cnt3=%b cnt4=%b want 0 1", done_seen[3][0], done_seen[4][0]);
        end
        vectors++;
        if (done_seen[10][7] !== 1'b0 || done_seen[11][7] !== 1'b1 ||
            done_seen[10][56] !== 1'b0 || done_seen[11][56] !== 1'b1) begin
            miscompares++;
            $display("FAIL map_bit7_56: %b%b %b%b want 01 01", done_seen[10][7], done_seen[11][7], done_seen[10][56], done_seen[11][56]);
        end
        vectors++;
        if (done_seen[17][63] !== 1'b0 || done_seen[18][63] !== 1'b1) begin
            miscompares++;
            $display("FAIL map_bit63: cnt17=%b cnt18=%b want 0 1", done_seen[17][63], done_seen[18][63]);
        end
        release_a();
    endtask

    task automatic test_back_to_back();
        int n;
        start_a();
        run_a(1'b0, -1, n);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (a_dv !== 1'b1 || a_done !== {64{1'b1}} || a_cnt !== 5'd18 || a_row !== 8'h00) begin
                miscompares++;
                $display("FAIL backpressure_hold k=%0d: dv=%b done=%h cnt=%0d row=%h", k, a_dv, a_done, a_cnt, a_row);
            end
        end
        a_dr = 1'b1;
        a_sv = 1'b1;
        @(negedge clk);
        a_dr = 1'b0;
        vectors++;
        if (a_sr !== 1'b1 || a_busy !== 1'b0 || a_dv !== 1'b0 || a_done !== {64{1'b1}}) begin
            miscompares++;
            $display("FAIL idle_gap: sr=%b busy=%b dv=%b done=%h want 1 0 0 all ones", a_sr, a_busy, a_dv, a_done);
        end
        start_a();
        run_a(1'b0, -1, n);
        vectors++;
        if (n !== 19) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d want 19", n);
        end
        release_a();
    endtask

    task automatic test_ignored_start();
        int n;
        start_a();
        run_a(1'b1, -1, n);
        vectors++;
        if (n !== 19) begin
            miscompares++;
            $display("FAIL ignored_latency: got %0d want 19", n);
        end
        for (int k = 0; k < 8; k++) begin
            a_sv = ($urandom_range(1, 0) == 1);
            @(negedge clk);
            vectors++;
            if (a_dv !== 1'b1 || a_cnt !== 5'd18 || a_sr !== 1'b0) begin
                miscompares++;
                $display("FAIL ignored_done k=%0d: dv=%b cnt=%0d sr=%b want 1 18 0", k, a_dv, a_cnt, a_sr);
            end
        end
        release_a();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (a_busy !== 1'b0 || a_sr !== 1'b1) begin
                miscompares++;
                $display("FAIL no_queued_tile k=%0d: busy=%b sr=%b want 0 1", k, a_busy, a_sr);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        start_a();
        run_a(1'b0, 9, n);
        @(negedge clk);
        vectors++;
        if (a_sr !== 1'b1 || a_busy !== 1'b0 || a_dv !== 1'b0 || a_cnt !== 5'd0 ||
            a_row !== 8'h00 || a_col !== 8'h00 || a_first !== 64'h0 || a_done !== 64'h0) begin
            miscompares++;
            $display("FAIL mid_run_reset: sr=%b busy=%b dv=%b cnt=%0d row=%h col=%h first=%h done=%h",
                     a_sr, a_busy, a_dv, a_cnt, a_row, a_col, a_first, a_done);
        end
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        start_a();
        run_a(1'b0, -1, n);
        vectors++;
        if (n !== 19 || row_seen[0] !== 8'h01 || row_seen[10] !== 8'h80) begin
            miscompares++;
            $display("FAIL after_reset_tile: latency=%0d row0=%h row10=%h want 19 01 80", n, row_seen[0], row_seen[10]);
        end
        release_a();
    endtask

    task automatic test_corner_small();
        logic [3:0]  fs [0:63];
        logic [3:0]  ds [0:63];
        logic [63:0] f;
        logic [63:0] rise;
        int          n = -1;
        b_sv = 1'b1;
        vectors++;
        if (b_sr !== 1'b1) begin
            miscompares++;
            $display("FAIL small_start_ready: got %b want 1", b_sr);
        end
        @(posedge clk);
        for (int idx = 0; idx < 50; idx++) begin
            @(negedge clk);
            b_sv = 1'b0;
            ds[idx] = b_done;
            if (b_dv === 1'b1) begin
                n = idx;
                break;
            end
            fs[idx] = b_first;
            f = m_feed(2, 1, idx);
            vectors++;
            if (b_cnt !== 2'(idx) || b_row !== f[1:0] || b_col !== f[1:0]) begin
                miscompares++;
                $display("FAIL small_feed idx=%0d: cnt=%0d row=%h col=%h want %0d %h", idx, b_cnt, b_row, b_col, idx, f[1:0]);
            end
        end
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL small_latency: got %0d want 4", n);
        end else begin
            vectors++;
            if (ds[4] !== 4'hF) begin
                miscompares++;
                $display("FAIL small_done_map: got %h want f", ds[4]);
            end
            for (int c = 0; c < 4; c++) begin
                rise = m_first(2, c);
                vectors++;
                if (fs[c] !== (ds[c+1] & ~ds[c]) || fs[c] !== rise[3:0]) begin
                    miscompares++;
                    $display("FAIL small_first_vs_rise cnt=%0d: first=%h rise=%h want %h", c, fs[c], ds[c+1] & ~ds[c], rise[3:0]);
                end
            end
        end
        b_dr = 1'b1;
        @(negedge clk);
        b_dr = 1'b0;
    endtask

    task automatic test_corner_deep();
        logic [63:0] f;
        int          n = -1;
        int          last_col3 = -1;
        c_sv = 1'b1;
        @(posedge clk);
        for (int idx = 0; idx < 60; idx++) begin
            @(negedge clk);
            c_sv = 1'b0;
            if (c_dv === 1'b1) begin
                n = idx;
                break;
            end
            if (c_col[3] === 1'b1) last_col3 = idx;
            f = m_feed(4, 16, idx);
            vectors++;
            if (c_col !== f[3:0] || c_row !== f[3:0]) begin
                miscompares++;
                $display("FAIL deep_feed idx=%0d: row=%h col=%h want %h", idx, c_row, c_col, f[3:0]);
            end
        end
        vectors++;
        if (n !== 23) begin
            miscompares++;
            $display("FAIL deep_latency: got %0d want 23", n);
        end
        vectors++;
        if (last_col3 !== 18) begin
            miscompares++;
            $display("FAIL deep_last_col3: got %0d want 18", last_col3);
        end
        c_dr = 1'b1;
        @(negedge clk);
        c_dr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_tile();
        test_completion_map();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_run();
        test_corner_small();
        test_corner_deep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_tile_sequencer.md
# systolic_tile_sequencer

Sequences one output tile through the SIZE×SIZE output-stationary systolic array. After accepting a start request it drives the skewed row and column operand-feed enables and tracks per-PE completion as a SIZE*SIZE-bit map. It then holds a done handshake until the readout side consumes the tile. It sits between the tile-level controller and the wrapper that feeds the PE grid, and its `pe_done` map uses the same bit layout as the array's per-PE finish vector.

## Interface
- `SIZE`, default 8: array edge length (rows = columns).
- `DEPTH`, default 4: reduction length K, i.e. operands per PE per tile; must be ≥ 1.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `start_valid`  in  1: tile start request.
- `start_ready`  out  1: high only in IDLE.
- `busy`  out  1: high in RUN or DONE.
- `cnt`  out  $clog2(DEPTH+2*SIZE-1): global tile cycle counter.
- `row_feed_en`  out  SIZE: bit r enables the left-edge operand injection for row r.
- `col_feed_en`  out  SIZE: bit c enables the top-edge operand injection for column c.
- `pe_first`  out  SIZE*SIZE: bit i*SIZE+j is high in the cycle PE(i,j) receives k=0; it is the accumulator-clear qualifier.
- `pe_done`  out  SIZE*SIZE: bit i*SIZE+j is a sticky finish flag for PE(i,j).
- `done_valid`  out  1: the whole tile is complete and the results are stable.
- `done_ready`  in  1: the readout side accepts the tile.

## Operation
- **LAST** = DEPTH + 2*SIZE − 2.
- **States:** IDLE, RUN, DONE. The state register is 2 bits.
- **IDLE:**
  - `start_ready`=1, `cnt`=0, all feed enables are 0.
  - `start_valid`&&`start_ready` at an edge moves to RUN with `cnt`=0 and clears `pe_done` to 0 at the same edge.
- **RUN:**
  - `cnt` increments by 1 each cycle.
  - At the edge where `cnt`==LAST, go to DONE; `cnt` holds at LAST.
  - `row_feed_en[r]` = (`cnt` ≥ r) && (`cnt` < r+DEPTH). This is combinational from `cnt` and state, and 0 outside RUN.
  - `col_feed_en[c]` follows the same rule with c.
  - `pe_first[i*SIZE+j]` = RUN && (`cnt` == i+j).
  - PE(i,j) receives its last operand at `cnt` = i+j+DEPTH−1. `pe_done[i*SIZE+j]` is registered and set at the edge ending that cycle, so it is visible at `cnt` = i+j+DEPTH.
- **DONE:**
  - `done_valid`=1, feed enables are 0, `pe_done` is all ones.
  - `done_valid`&&`done_ready` at an edge moves to IDLE.
  - `pe_done` is retained in IDLE and cleared only by the next start acceptance or by reset.
- **Ignored inputs:**
  - `start_valid` outside IDLE is ignored; it is neither queued nor an error.
  - `done_ready` outside DONE is ignored.
- **Arithmetic:** the `cnt` compares are unsigned, at the `cnt` width zero-extended; r+DEPTH is evaluated without overflow.

## Timing
- **Reset values (rst=1 at an edge):**
  - State IDLE, `cnt`=0, `pe_done`=0.
  - Outputs: `start_ready`=1, `busy`=0, `done_valid`=0, all feed enables and `pe_first` are 0.
- **Reset mid-operation:** reset mid-RUN or mid-DONE aborts the tile immediately, with no done pulse and no residual enables in the next cycle.
- **Cycle numbering:** the start handshake edge is E0. The first RUN cycle has `cnt`=0, and the final RUN cycle has `cnt`=LAST.
- **Latencies:**
  - `done_valid` rises in the cycle after `cnt`=LAST, i.e. LAST+1 cycles after E0.
  - Start-to-done is therefore DEPTH+2*SIZE−1 cycles.
- **Back-to-back tiles:**
  - Done handshake at edge Ed gives `start_ready`=1 in the cycle after Ed.
  - The minimum gap between tiles is 1 idle cycle; there is no overlap of tiles.
- **Backpressure:** `done_ready` may be held low indefinitely and DONE is stable throughout.
- **DEPTH=1:** feed enables are one-hot diagonal pulses, `pe_first` and the last operand coincide, and `pe_done` bit i*SIZE+j is visible at `cnt`=i+j+1.

## Test plan
1. **Basic tile (SIZE=8, DEPTH=4, LAST=18):**
   - Stimulus: reset, then start_valid=1 for one cycle.
   - Required: `start_ready` drops at `cnt`=0.
   - Required: `row_feed_en` = 8'h01 at `cnt` 0, 8'h0F at `cnt` 3, 8'hF0 at `cnt` 7, 8'h80 at `cnt` 10, 0 at `cnt` 11.
   - Required: `done_valid`=1 exactly 19 cycles after E0.
2. **Completion map:**
   - Monitor `pe_done` each cycle.
   - Required: bit 0 rises at `cnt`=4, bit 7 and bit 56 at `cnt`=11, bit 63 at `cnt`=18.
   - Required: no bit rises before i+j+4, and all 64 bits are 1 in DONE.
3. **Backpressure and back-to-back:**
   - Stimulus: hold `done_ready`=0 for 10 cycles.
   - Required: `done_valid` and `pe_done` remain stable.
   - Stimulus: assert `done_ready`, then `start_valid` held high.
   - Required: IDLE lasts 1 cycle, and `pe_done` reads 0 at the new `cnt`=0.
4. **Ignored start:**
   - Stimulus: toggle `start_valid` throughout RUN and DONE.
   - Required: `cnt`, state and enables are unaffected, with exactly one tile per accepted handshake.
5. **Reset mid-run:**
   - Stimulus: `rst`=1 at `cnt`=9.
   - Required: next cycle all outputs are at their reset values and `pe_done`=0.
   - Required: a subsequent start behaves identically to scenario 1.
6. **Corner parameters:**
   - SIZE=2, DEPTH=1: `done_valid` 4 cycles after E0, and `pe_first` equals the `pe_done` rise pattern shifted one cycle earlier.
   - SIZE=4, DEPTH=16: last `col_feed_en[3]` at `cnt`=18.
